// File: rtl/instr_mem_loader_if.sv
// Byte-stream load port and instruction-memory write port of instr_mem_loader.
interface instr_mem_loader_if #(
    parameter int DATA_WIDTH = 39,
    parameter int ADDR_WIDTH = 6
);
    logic                  start;
    logic [ADDR_WIDTH:0]   len;
    logic [7:0]            byte_in;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  busy;
    logic                  done;
    logic                  checksum_err;

    // A byte transfers on a rising edge where byte_valid and byte_ready are
    // both 1; byte_in must be stable while byte_valid is high, and byte_ready
    // never depends combinationally on byte_valid.
    modport master (
        output start, len, byte_in, byte_valid,
        input  byte_ready, we, addr, data, busy, done, checksum_err
    );

    modport slave (
        input  start, len, byte_in, byte_valid,
        output byte_ready, we, addr, data, busy, done, checksum_err
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Assembles LSB-first byte stream into instruction words and writes them from address 0.
// Optional XOR checksum trailer word enabled by macro LOADER_CHECKSUM_EN.
module instr_mem_loader #(
    parameter int DATA_WIDTH = 39,
    parameter int ADDR_WIDTH = 6
) (
    input  logic               Clk,
    input  logic               Reset,
    instr_mem_loader_if.slave  bus,
    output logic [2:0]         dbg_state
);
    localparam int NBYTES  = (DATA_WIDTH + 7) / 8;
    localparam int SHIFT_W = (NBYTES - 1) * 8;
    localparam int CNT_W   = $clog2(NBYTES);
    localparam int LEN_W   = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);
    localparam logic [LEN_W-1:0] MAX_LEN   = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK = 3'd4,
`endif
        S_DONE  = 3'd3
    } state_t;

    state_t                state;
    logic [SHIFT_W-1:0]    word_buf;
    logic [CNT_W-1:0]      byte_cnt;
    logic [LEN_W-1:0]      words_left;
    logic                  byte_ready_r;
    logic                  we_r;
    logic                  busy_r;
    logic                  done_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] data_r;

    logic                  byte_fire;
    logic                  last_byte;
    logic [DATA_WIDTH-1:0] next_word;

    assign byte_fire = bus.byte_valid & byte_ready_r;
    assign last_byte = (byte_cnt == LAST_BYTE);
    // Earlier bytes sit below the incoming one; bits past DATA_WIDTH are dropped.
    assign next_word = DATA_WIDTH'({bus.byte_in, word_buf});

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum;
    logic                  csum_err_r;
    assign bus.checksum_err = csum_err_r;
`else
    assign bus.checksum_err = 1'b0;
`endif

    assign bus.byte_ready = byte_ready_r;
    assign bus.we         = we_r;
    assign bus.addr       = addr_r;
    assign bus.data       = data_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign dbg_state      = state;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= S_IDLE;
            word_buf     <= '0;
            byte_cnt     <= '0;
            words_left   <= '0;
            byte_ready_r <= 1'b0;
            we_r         <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            addr_r       <= '0;
            data_r       <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum         <= '0;
            csum_err_r   <= 1'b0;
`endif
        end else begin
            we_r   <= 1'b0;
            done_r <= 1'b0;

            // Byte collection is shared by RECV and CHECK; ready is only high there.
            if (byte_fire) begin
                if (last_byte) begin
                    byte_cnt <= '0;
                end else begin
                    byte_cnt <= byte_cnt + CNT_W'(1);
                    word_buf <= {bus.byte_in, word_buf[SHIFT_W-1:8]};
                end
            end

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        busy_r   <= 1'b1;
                        byte_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum       <= '0;
                        csum_err_r <= 1'b0;
`endif
                        if (bus.len == '0) begin
                            state <= S_DONE;
                        end else begin
                            addr_r       <= '0;
                            words_left   <= (bus.len > MAX_LEN) ? MAX_LEN : bus.len;
                            byte_ready_r <= 1'b1;
                            state        <= S_RECV;
                        end
                    end
                end
                S_RECV: begin
                    if (byte_fire && last_byte) begin
                        data_r       <= next_word;
                        we_r         <= 1'b1;
                        byte_ready_r <= 1'b0;
                        state        <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    addr_r     <= addr_r + ADDR_WIDTH'(1);
                    words_left <= words_left - LEN_W'(1);
`ifdef LOADER_CHECKSUM_EN
                    csum <= csum ^ data_r;
`endif
                    if (words_left == LEN_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                        byte_ready_r <= 1'b1;
                        state        <= S_CHECK;
`else
                        state <= S_DONE;
`endif
                    end else begin
                        byte_ready_r <= 1'b1;
                        state        <= S_RECV;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    // Trailer word is compared, never written to memory.
                    if (byte_fire && last_byte) begin
                        csum_err_r   <= (next_word != csum);
                        byte_ready_r <= 1'b0;
                        state        <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized self-checking bench for instr_mem_loader against a word-level load model.
module tb_instr_mem_loader;
    localparam int DW    = 39;
    localparam int AW    = 6;
    localparam int LW    = AW + 1;
    localparam int NB    = 5;
    localparam int DEPTH = 64;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [2:0] dbg_state;

    always #5 Clk = ~Clk;

    instr_mem_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    instr_mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int             checks = 0;
    int             errors = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [39:0]    word_src[$];
    int             busy_bad = 0;
    int             we_bad = 0;
    int             ready_bad = 0;
    int             hold_bad = 0;
    int             state_bad = 0;
    int             done_cnt = 0;
    bit             load_active = 1'b0;
    logic [2:0]     idle_code;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write port monitor: every write must match the next expected {addr,data}.
    initial begin : monitor
        logic [AW+DW-1:0] e;
        logic             prev_we;
        logic [DW-1:0]    prev_data;
        prev_we   = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge Clk);
            if (Reset !== 1'b0) begin
                prev_we   = 1'b0;
                prev_data = bus.data;
            end else begin
                if (bus.we) begin
                    if (prev_we) we_bad++;
                    if (bus.byte_ready) ready_bad++;
                    if (exp_q.size() == 0) begin
                        check("we_unexpected", 64'(bus.we), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", 64'(bus.addr), 64'(e[AW+DW-1:DW]));
                        check("wr_data", 64'(bus.data), 64'(e[DW-1:0]));
                    end
                end else if (bus.data !== prev_data) begin
                    hold_bad++;
                end
                if (load_active && !bus.done && !bus.busy) busy_bad++;
                if (bus.busy && dbg_state == idle_code) state_bad++;
                if (bus.done) done_cnt++;
                prev_we   = bus.we;
                prev_data = bus.data;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        Reset          = 1'b1;
        bus.start      = 1'b0;
        bus.len        = '0;
        bus.byte_in    = '0;
        bus.byte_valid = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        exp_q.delete();
        load_active = 1'b0;
    endtask

    task automatic check_reset_outputs();
        @(negedge Clk);
        check("rst_byte_ready", 64'(bus.byte_ready), 64'd0);
        check("rst_we", 64'(bus.we), 64'd0);
        check("rst_addr", 64'(bus.addr), 64'd0);
        check("rst_data", 64'(bus.data), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_checksum_err", 64'(bus.checksum_err), 64'd0);
    endtask

    // mode: 0 = valid always, 1 = valid toggles every cycle, 2 = random gaps.
    // inject_at >= 0 raises start again in that driver cycle (must be ignored).
    task automatic do_load(input int len, input int mode, input bit corrupt, input int inject_at);
        logic [7:0]    bq[$];
        logic [DW-1:0] x;
        logic [DW-1:0] m;
        logic [39:0]   ck;
        int            n, idx, cyc, found_at, done_before;
        bit            fire, got, exp_err;
        n       = (len > DEPTH) ? DEPTH : len;
        x       = '0;
        exp_err = 1'b0;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            m = word_src[i][DW-1:0];
            exp_q.push_back({AW'(i % DEPTH), m});
            x = x ^ m;
            for (int b = 0; b < NB; b++) bq.push_back(word_src[i][8*b +: 8]);
        end
`ifdef LOADER_CHECKSUM_EN
        if (n > 0) begin
            ck = {1'($urandom_range(0, 1)), x ^ DW'(corrupt)};
            for (int b = 0; b < NB; b++) bq.push_back(ck[8*b +: 8]);
            exp_err = corrupt;
        end
`endif
        done_before = done_cnt;
        bus.len   = LW'(len);
        bus.start = 1'b1;
        @(posedge Clk);
        #1;
        bus.start   = 1'b0;
        bus.len     = LW'($urandom);
        load_active = 1'b1;

        idx = 0;
        cyc = 0;
        while (idx < bq.size() && cyc < 40 * bq.size() + 50) begin
            bus.byte_in = bq[idx];
            case (mode)
                0:       bus.byte_valid = 1'b1;
                1:       bus.byte_valid = (cyc % 2 == 0);
                default: bus.byte_valid = ($urandom_range(0, 3) != 0);
            endcase
            bus.start = (cyc == inject_at);
            bus.len   = LW'($urandom_range(1, 5));
            @(negedge Clk);
            fire = bus.byte_valid && bus.byte_ready;
            @(posedge Clk);
            #1;
            if (fire) idx++;
            cyc++;
        end
        bus.byte_valid = 1'b0;
        bus.start      = 1'b0;
        check("bytes_accepted", 64'(idx), 64'(bq.size()));

        got      = 1'b0;
        found_at = -1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge Clk);
            if (bus.done) begin
                got      = 1'b1;
                found_at = c;
            end
        end
        check("done_seen", 64'(got), 64'd1);
        if (len == 0) check("zero_len_done_latency", 64'(found_at), 64'd1);
        check("busy_at_done", 64'(bus.busy), 64'd0);
        if (n > 0) check("addr_after_load", 64'(bus.addr), 64'(n % DEPTH));
        check("pending_writes", 64'(exp_q.size()), 64'd0);
        check("checksum_err", 64'(bus.checksum_err), 64'(exp_err));
        load_active = 1'b0;
        @(negedge Clk);
        check("done_width", 64'(bus.done), 64'd0);
        check("done_count", 64'(done_cnt - done_before), 64'd1);
        check("idle_byte_ready", 64'(bus.byte_ready), 64'd0);
        exp_q.delete();
    endtask

    task automatic fill_random(input int n);
        word_src.delete();
        for (int i = 0; i < n; i++) word_src.push_back({8'($urandom), 32'($urandom)});
    endtask

    initial begin : stimulus
        int  fires;
        bit  fire;
        do_reset();
        check_reset_outputs();
        idle_code = dbg_state;

        // Two words: low byte only, then all-ones with bit 39 discarded.
        word_src.delete();
        word_src.push_back(40'h00_0000_0001);
        word_src.push_back(40'hFF_FFFF_FFFF);
        do_load(2, 0, 1'b0, -1);

        do_load(0, 0, 1'b0, -1);

        fill_random(1);
        do_load(1, 1, 1'b0, -1);

        fill_random(3);
        do_load(3, 0, 1'b0, 4);

        // Reset after three bytes of word 0 discards the partial word.
        fill_random(2);
        bus.len   = LW'(2);
        bus.start = 1'b1;
        @(posedge Clk);
        #1 bus.start = 1'b0;
        fires = 0;
        for (int c = 0; c < 30 && fires < 3; c++) begin
            bus.byte_in    = word_src[0][8*fires +: 8];
            bus.byte_valid = 1'b1;
            @(negedge Clk);
            fire = bus.byte_ready;
            @(posedge Clk);
            #1;
            if (fire) fires++;
        end
        check("partial_bytes", 64'(fires), 64'd3);
        do_reset();
        check_reset_outputs();
        fill_random(2);
        do_load(2, 2, 1'b0, -1);

        // Full depth, word i = i, address wraps back to 0.
        word_src.delete();
        for (int i = 0; i < DEPTH; i++) word_src.push_back(40'(i));
        do_load(DEPTH, 0, 1'b0, -1);

        // Oversized length is clamped to the full depth.
        fill_random(DEPTH);
        do_load(DEPTH + $urandom_range(1, 63), 2, 1'b0, -1);

        for (int t = 0; t < 6; t++) begin
            int l;
            l = $urandom_range(1, 12);
            fill_random(l);
            do_load(l, $urandom_range(0, 2), 1'($urandom_range(0, 1)), -1);
        end

        word_src.delete();
        word_src.push_back(40'h3);
        word_src.push_back(40'h5);
        do_load(2, 0, 1'b0, -1);
        do_load(2, 0, 1'b1, -1);

        check("busy_dropped_during_load", 64'(busy_bad), 64'd0);
        check("we_longer_than_one_cycle", 64'(we_bad), 64'd0);
        check("byte_ready_during_write", 64'(ready_bad), 64'd0);
        check("data_changed_without_we", 64'(hold_bad), 64'd0);
        check("busy_while_idle_state", 64'(state_bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 39, instruction word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 6, instruction memory address width.
REQ-003 The block SHALL have port Clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, one-cycle request to begin a load at address 0.
REQ-006 The block SHALL have port len, input, ADDR_WIDTH+1, number of words to load, sampled on accepted start.
REQ-007 The block SHALL have port byte_in, input, 8, serial load byte.
REQ-008 The block SHALL have port byte_valid, input, 1, byte_in holds a valid byte.
REQ-009 The block SHALL have port byte_ready, output, 1, loader accepts byte this cycle.
REQ-010 The block SHALL have port we, output, 1, write strobe to instruction memory.
REQ-011 The block SHALL have port addr, output, ADDR_WIDTH, write address.
REQ-012 The block SHALL have port data, output, DATA_WIDTH, write data.
REQ-013 The block SHALL have port busy, output, 1, high from accepted start until the cycle done is asserted.
REQ-014 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-015 The block SHALL have port checksum_err, output, 1, checksum mismatch flag (see Configuration).

Function
REQ-016 States SHALL be IDLE, RECV, WRITE, DONE (plus CHECK when REQ-031 applies).
REQ-017 IDLE: start=1 with len!=0 SHALL go to RECV, clear addr to 0, and latch len clamped to 2**ADDR_WIDTH; start with len=0 SHALL go directly to DONE.
REQ-018 A byte SHALL be accepted only in a cycle where byte_valid=1 and byte_ready=1; byte_ready SHALL be 1 only in RECV/CHECK.
REQ-019 Each word SHALL be assembled from ceil(DATA_WIDTH/8)=5 accepted bytes, LSB byte first; bits above DATA_WIDTH-1 in the final byte SHALL be discarded.
REQ-020 The cycle after the 5th byte is accepted, the state SHALL be WRITE with we=1 for exactly one cycle, data=assembled word, and addr=current word address.
REQ-021 After WRITE, addr SHALL increment by 1; if the written word was word len-1, the next state SHALL be DONE (or CHECK per REQ-031), otherwise RECV.
REQ-022 Addr increment from 2**ADDR_WIDTH-1 SHALL wrap to 0 and SHALL only occur when len=2**ADDR_WIDTH, immediately before DONE.
REQ-023 DONE SHALL assert done=1 for one cycle, deassert busy in that same cycle, and return to IDLE.
REQ-024 start while not in IDLE SHALL be ignored; byte_valid in IDLE/WRITE/DONE SHALL be ignored, with no byte consumed.
REQ-025 we SHALL never be asserted outside WRITE; data and addr SHALL hold their values when we=0.

Reset
REQ-026 Reset=1 SHALL force IDLE on the next rising edge, overriding all other inputs including start.
REQ-027 Reset values SHALL be byte_ready=0, we=0, addr=0, data=0, busy=0, done=0, checksum_err=0, and the byte counter and partial word SHALL be cleared.
REQ-028 Reset during RECV SHALL discard the partial word without issuing any write.

Configuration
REQ-029 Macro LOADER_CHECKSUM_EN SHALL select the checksum feature at compile time.
REQ-030 Without LOADER_CHECKSUM_EN, checksum_err SHALL be tied to 0, no CHECK state SHALL exist, and the last WRITE SHALL go to DONE.
REQ-031 With LOADER_CHECKSUM_EN, the block SHALL keep a running XOR of all written words (cleared on accepted start); after the last WRITE it SHALL enter CHECK, accept one more 5-byte word without writing it, and compare that word to the XOR.
REQ-032 After CHECK, checksum_err SHALL be set to 1 on mismatch and 0 on match; it SHALL hold until the next accepted start or Reset; the state SHALL then proceed to DONE.

Verification
REQ-033 Load len=2, bytes 01 00 00 00 00, FF FF FF FF FF -> we pulses at addr 0 with data 0x0000000001 and at addr 1 with data 0x7FFFFFFFFF; done pulses once.
REQ-034 len=64 with word i = i -> 64 writes at addr 0..63; addr wraps to 0; done pulses; busy is high throughout.
REQ-035 byte_valid toggled 1/0 every cycle during len=1 -> exactly 5 bytes consumed; we asserted once; byte_ready=0 during the WRITE cycle.
REQ-036 Reset asserted after 3 bytes of word 0 -> no we pulse; all outputs return to reset values; a new start loads correctly from addr 0.
REQ-037 start with len=0 -> done pulses 2 cycles later with no we; start asserted mid-load -> ignored.
REQ-038 With LOADER_CHECKSUM_EN, words 0x3 and 0x5, checksum 0x6 -> checksum_err=0; checksum 0x7 -> checksum_err=1; checksum word not written.
